// File: rtl/rx_arbiter.sv
// rtl/rx_arbiter.sv - packet-locking five-port arbiter; round-robin when RX_ARB_RR_EN is defined, fixed priority otherwise
`ifndef SIZE
`define SIZE 16
`endif

module rx_arbiter #(
  parameter int PKT_FLITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             full,
  input  logic             n_valid,
  input  logic             s_valid,
  input  logic             e_valid,
  input  logic             w_valid,
  input  logic             l_valid,
  input  logic [`SIZE-1:0] n_item,
  input  logic [`SIZE-1:0] s_item,
  input  logic [`SIZE-1:0] e_item,
  input  logic [`SIZE-1:0] w_item,
  input  logic [`SIZE-1:0] l_item,
  output logic             n_read,
  output logic             s_read,
  output logic             e_read,
  output logic             w_read,
  output logic             l_read,
  output logic [`SIZE-1:0] item_out,
  output logic             write,
  output logic [4:0]       grant,
  output logic             busy
);

  localparam int CNT_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_FLITS - 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       base;

  logic [4:0]       valid_vec;
  logic [`SIZE-1:0] item_arr [5];
  logic             found;
  logic [2:0]       sel;
  logic [3:0]       idx;
  logic             xfer;
  logic [4:0]       rd_vec;

  // Next port after x, wrapping L back to N.
  function automatic logic [2:0] inc5(input logic [2:0] x);
    return (x >= 3'd4) ? 3'd0 : x + 3'd1;
  endfunction

  assign valid_vec = {l_valid, w_valid, e_valid, s_valid, n_valid};
  assign item_arr[0] = n_item;
  assign item_arr[1] = s_item;
  assign item_arr[2] = e_item;
  assign item_arr[3] = w_item;
  assign item_arr[4] = l_item;

`ifdef RX_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d;
  // Out-of-range pointer values fold back to N.
  assign base = (ptr_q > 3'd4) ? 3'd0 : ptr_q;
`else
  assign base = 3'd0;
`endif

  // Selection: owner while locked, otherwise first valid port from base.
  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    idx   = 4'd0;
    if (state_q == LOCKED) begin
      found = 1'b1;
      sel   = owner_q;
    end else begin
      for (int k = 0; k < 5; k++) begin
        idx = {1'b0, base} + 4'(k);
        if (idx >= 4'd5) idx = idx - 4'd5;
        if (!found && valid_vec[idx[2:0]]) begin
          found = 1'b1;
          sel   = idx[2:0];
        end
      end
    end
  end

  // Datapath and strobes; a locked owner without data shows a bubble.
  always_comb begin
    grant    = found ? (5'b00001 << sel) : 5'b00000;
    item_out = found ? item_arr[sel] : '0;
    xfer     = found && valid_vec[sel] && !full;
    rd_vec   = xfer ? grant : 5'b00000;
    write    = xfer;
    busy     = (state_q == LOCKED);
  end

  assign n_read = rd_vec[0];
  assign s_read = rd_vec[1];
  assign e_read = rd_vec[2];
  assign w_read = rd_vec[3];
  assign l_read = rd_vec[4];

  // Packet lock bookkeeping advances only on an actual transfer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
`ifdef RX_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    if (xfer) begin
      case (state_q)
        IDLE: begin
          if (PKT_FLITS == 1) begin
`ifdef RX_ARB_RR_EN
            ptr_d = inc5(sel);
`endif
          end else begin
            state_d = LOCKED;
            owner_d = sel;
            cnt_d   = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef RX_ARB_RR_EN
            ptr_d   = inc5(owner_q);
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset; reset drops any held lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 3'd0;
      cnt_q   <= '0;
`ifdef RX_ARB_RR_EN
      ptr_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
`ifdef RX_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_rx_arbiter.sv
// tb/tb_rx_arbiter.sv - directed scoreboard bench for rx_arbiter (PKT_FLITS 4 and 1)
`ifndef SIZE
`define SIZE 16
`endif

module tb_rx_arbiter;

`ifdef RX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int               port;
    logic [`SIZE-1:0] item;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic full = 1'b0;
  logic [4:0] v_in = 5'b0;
  logic [`SIZE-1:0] it [5];

  logic [4:0] rd4, rd1, grant4, grant1;
  logic [`SIZE-1:0] item4, item1;
  logic write4, write1, busy4, busy1;

  exp_t q4[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  rx_arbiter #(.PKT_FLITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .full(full),
    .n_valid(v_in[0]), .s_valid(v_in[1]), .e_valid(v_in[2]), .w_valid(v_in[3]), .l_valid(v_in[4]),
    .n_item(it[0]), .s_item(it[1]), .e_item(it[2]), .w_item(it[3]), .l_item(it[4]),
    .n_read(rd4[0]), .s_read(rd4[1]), .e_read(rd4[2]), .w_read(rd4[3]), .l_read(rd4[4]),
    .item_out(item4), .write(write4), .grant(grant4), .busy(busy4)
  );

  rx_arbiter #(.PKT_FLITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .full(full),
    .n_valid(v_in[0]), .s_valid(v_in[1]), .e_valid(v_in[2]), .w_valid(v_in[3]), .l_valid(v_in[4]),
    .n_item(it[0]), .s_item(it[1]), .e_item(it[2]), .w_item(it[3]), .l_item(it[4]),
    .n_read(rd1[0]), .s_read(rd1[1]), .e_read(rd1[2]), .w_read(rd1[3]), .l_read(rd1[4]),
    .item_out(item1), .write(write1), .grant(grant1), .busy(busy1)
  );

  function automatic logic [4:0] oh(input int p);
    return 5'(1 << p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One cycle: ep/ep1 = expected transferring port (-1 none, -2 skip dut1),
  // eg = expected grant (-1 don't care), eb = expected busy (-1 don't care).
  task automatic step(input logic [4:0] v, input logic f, input int ep, input int eg,
                      input int eb, input int ep1);
    exp_t e;
    cyc++;
    v_in = v;
    full = f;
    for (int p = 0; p < 5; p++) it[p] = `SIZE'((p << 12) | (cyc & 12'hfff));
    if (ep >= 0) begin
      e.port = ep; e.item = it[ep]; q4.push_back(e);
    end
    if (ep1 >= 0) begin
      e.port = ep1; e.item = it[ep1]; q1.push_back(e);
    end
    @(negedge clk);
    chk("write", 32'(write4), 32'(q4.size() != 0));
    if (q4.size() != 0) begin
      e = q4.pop_front();
      chk("reads", 32'(rd4), 32'(oh(e.port)));
      chk("item_out", 32'(item4), 32'(e.item));
      chk("grant_xfer", 32'(grant4), 32'(oh(e.port)));
    end else begin
      chk("reads_idle", 32'(rd4), 32'd0);
    end
    if (eg >= 0) chk("grant", 32'(grant4), 32'(eg));
    if (eb >= 0) chk("busy", 32'(busy4), 32'(eb));
    if (ep1 >= -1) begin
      chk("write1", 32'(write1), 32'(q1.size() != 0));
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("grant1", 32'(grant1), 32'(oh(e.port)));
        chk("reads1", 32'(rd1), 32'(oh(e.port)));
        chk("item1", 32'(item1), 32'(e.item));
      end else begin
        chk("grant1_idle", 32'(grant1), 32'd0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic s(input logic [4:0] v, input logic f, input int ep, input int eg, input int eb);
    step(v, f, ep, eg, eb, -2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v_in = 5'b0;
    full = 1'b0;
    @(posedge clk);
    #1;
    step(5'b0, 1'b0, -1, 0, 0, -1);
    reset = 1'b0;
  endtask

  initial begin
    int p;
    for (int k = 0; k < 5; k++) it[k] = '0;
    do_reset();

    // All ports valid: N packet, then S (round-robin) or N again.
    for (int i = 0; i < 4; i++) s(5'h1f, 1'b0, 0, -1, (i == 0) ? 0 : 1);
    p = RR ? 1 : 0;
    for (int i = 0; i < 4; i++) s(5'h1f, 1'b0, p, -1, (i == 0) ? 0 : 1);

    // N locked with S waiting; S must not be read until N completes.
    for (int i = 0; i < 4; i++) s(5'b00011, 1'b0, 0, -1, (i == 0) ? 0 : 1);
    p = RR ? 1 : 0;
    for (int i = 0; i < 4; i++) s(5'b00011, 1'b0, p, -1, (i == 0) ? 0 : 1);

    // Backpressure for 3 cycles mid-packet; exactly 4 writes overall.
    p = RR ? 2 : 0;
    s(5'h1f, 1'b0, p, -1, 0);
    s(5'h1f, 1'b0, p, -1, 1);
    for (int i = 0; i < 3; i++) s(5'h1f, 1'b1, -1, oh(p), 1);
    s(5'h1f, 1'b0, p, -1, 1);
    s(5'h1f, 1'b0, p, -1, 1);
    s(5'h00, 1'b0, -1, 0, 0);

    // Owner valid drops for 2 cycles while others (including E) stay valid.
    p = RR ? 3 : 0;
    s(5'h1f, 1'b0, p, -1, 0);
    s(5'h1f, 1'b0, p, -1, 1);
    for (int i = 0; i < 2; i++) s(5'h1f & ~oh(p), 1'b0, -1, oh(p), 1);
    s(5'h1f, 1'b0, p, -1, 1);
    s(5'h1f, 1'b0, p, -1, 1);
    s(5'h00, 1'b0, -1, 0, 0);

    // Reset while locked at cnt = 3; lock and pointer restart.
    p = RR ? 4 : 0;
    s(5'h1f, 1'b0, p, -1, 0);
    s(5'h1f, 1'b0, p, -1, 1);
    s(5'h1f, 1'b0, p, -1, 1);
    reset = 1'b1;
    v_in = 5'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    s(5'h00, 1'b0, -1, 0, 0);
    s(5'h1f, 1'b0, 0, -1, 0);
    for (int i = 0; i < 3; i++) s(5'h1f, 1'b0, 0, -1, 1);
    s(5'h00, 1'b0, -1, 0, 0);

    // Single-flit packets: grants rotate every cycle (or stay on N).
    do_reset();
    for (int i = 0; i < 6; i++)
      step(5'h1f, 1'b0, (i < 4) ? 0 : (RR ? 1 : 0), -1, -1, RR ? (i % 5) : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
